timer_display: RTL

TIMER_DISPLAY -- requirements
Module: timer_display

---
 rtl/timer_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 88 ++++++++
 rtl/timer_display.sv | 120 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared FSM encoding, seven-segment table and BCD helpers for
//            the timer display slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    localparam int unsigned c_bin_width    = 16;
    localparam int unsigned c_bcd_width    = 20;
    localparam logic [3:0]  c_shift_last   = 4'd15;
    localparam logic [7:0]  c_seg_blank    = 8'hFF;

    // Active-low patterns, index = decimal digit; bit 7 (dp) is always off.
    localparam logic [7:0] c_seg_table [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            seg_decode = c_seg_table[digit];
        end else begin
            seg_decode = c_seg_blank;
        end
    endfunction

    // Double-dabble correction: every BCD digit of 5 or more gets +3 so the
    // following left shift carries into the next digit correctly.
    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        logic [19:0] adj;
        adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative 16-bit binary to 5-digit BCD converter, one shift per
//            cycle. start is honoured in IDLE and in DONE (back-to-back).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    bcd_state_t  r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [19:0] w_adj;

    assign w_adj = bcd_adjust(r_bcd);
    assign bcd   = r_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_adj[18:0], r_bin[15]};
                    r_bin <= {r_bin[14:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    busy  <= 1'b1;
                    if (r_cnt == c_shift_last) begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    // The finished result stays on bcd for this cycle; a
                    // queued start reloads without passing through IDLE.
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_display.sv
// ============================================================================
// Module   : timer_display
// Purpose  : Converts timer counts to BCD and scans a 4-digit active-low
//            seven-segment display. Optional macro TIMER_DISPLAY_BLANK_EN
//            blanks leading zeros on digits 3..1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_display
    import timer_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        t_valid,
    input  logic [15:0] t_out,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        busy,
    output logic        ovf
);

    localparam logic [15:0] c_refresh_last = 16'(REFRESH_DIV - 1);

    logic        r_pend_flag;
    logic [15:0] r_pend_val;
    logic        w_start;
    logic        w_busy;
    logic        w_done;
    logic [19:0] w_bcd;

    logic [15:0] r_display;
    logic        r_ovf;
    logic [15:0] r_refresh_cnt;
    logic [1:0]  r_digit_sel;
    logic [3:0]  w_digit;
    logic        w_blank;

    // One request slot serves both the initial load and the pending value:
    // it is consumed whenever the converter can accept (IDLE or DONE), and
    // a new strobe always overwrites it so the latest value wins.
    assign w_start = r_pend_flag && (!w_busy || w_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_flag <= 1'b0;
            r_pend_val  <= '0;
        end else if (t_valid) begin
            r_pend_flag <= 1'b1;
            r_pend_val  <= t_out;
        end else if (w_start) begin
            r_pend_flag <= 1'b0;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (r_pend_val),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_display <= '0;
            r_ovf     <= 1'b0;
        end else if (w_done) begin
            r_display <= w_bcd[15:0];
            r_ovf     <= (w_bcd[19:16] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= '0;
        end else if (r_refresh_cnt == c_refresh_last) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= r_digit_sel + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 16'd1;
        end
    end

    always_comb begin
        w_digit = r_display[3:0];
        case (r_digit_sel)
            2'd0:    w_digit = r_display[3:0];
            2'd1:    w_digit = r_display[7:4];
            2'd2:    w_digit = r_display[11:8];
            2'd3:    w_digit = r_display[15:12];
            default: w_digit = r_display[3:0];
        endcase
    end

    always_comb begin
        w_blank = 1'b0;
`ifdef TIMER_DISPLAY_BLANK_EN
        case (r_digit_sel)
            2'd3:    w_blank = (r_display[15:12] == 4'd0);
            2'd2:    w_blank = (r_display[15:8] == 8'd0);
            2'd1:    w_blank = (r_display[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
`endif
    end

    assign an   = ~(4'b0001 << r_digit_sel);
    assign seg  = w_blank ? c_seg_blank : seg_decode(w_digit);
    assign busy = w_busy;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire
